// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchroniser, mid-bit sampling, one-cycle data/framing strobes.
// Optional parity bit (even/odd via PARITY_ODD) is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_data_valid,
  output logic       o_framing_error,
  output logic       o_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       o_parity_error
`endif
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] clk_ctr;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
`ifdef UART_RX_PARITY_EN
  logic          par_bit;
`endif

  assign o_busy = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta         <= 1'b1;
      rx_s            <= 1'b1;
      state           <= IDLE;
      clk_ctr         <= '0;
      bit_idx         <= '0;
      shift           <= '0;
      o_byte          <= '0;
      o_data_valid    <= 1'b0;
      o_framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit         <= 1'b0;
      o_parity_error  <= 1'b0;
`endif
    end else begin
      rx_meta         <= i_rx;
      rx_s            <= rx_meta;
      o_data_valid    <= 1'b0;
      o_framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_error  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            clk_ctr <= '0;
          end
        end
        // Start bit is re-checked at its centre so a short low glitch is rejected.
        START: begin
          if (clk_ctr == HALF) begin
            clk_ctr <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            clk_ctr <= clk_ctr + 1'b1;
          end
        end
        DATA: begin
          if (clk_ctr == LAST) begin
            clk_ctr         <= '0;
            shift[bit_idx]  <= rx_s;
            bit_idx         <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            clk_ctr <= clk_ctr + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (clk_ctr == LAST) begin
            clk_ctr <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            clk_ctr <= clk_ctr + 1'b1;
          end
        end
`endif
        // Leaving at mid-stop-bit gives half a bit of slack for the next start edge.
        STOP: begin
          if (clk_ctr == LAST) begin
            clk_ctr <= '0;
            if (!rx_s) begin
              o_framing_error <= 1'b1;
              state           <= WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
            end else if (par_bit != ((^shift) ^ PARITY_ODD)) begin
              o_parity_error <= 1'b1;
              state          <= IDLE;
`endif
            end else begin
              o_byte       <= shift;
              o_data_valid <= 1'b1;
              state        <= IDLE;
            end
          end else begin
            clk_ctr <= clk_ctr + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus queues expected strobes, a monitor pops and checks them.
module tb_uart_rx;
  localparam int unsigned CPB  = 16;
  localparam bit          PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam bit          PAR_EN = 1'b1;
`else
  localparam bit          PAR_EN = 1'b0;
`endif
  localparam int LAT = 2 + (CPB - 1) / 2 + 9 * CPB + 1 + (PAR_EN ? CPB : 0);

  localparam int K_VALID = 0;
  localparam int K_FRAME = 1;
  localparam int K_PAR   = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         start;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] dbyte;
  logic       dv, fe, busy, pe;

  exp_t       sb[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_good = 8'h00;

  uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(PODD)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_rx(rx),
    .o_byte(dbyte),
    .o_data_valid(dv),
    .o_framing_error(fe),
    .o_busy(busy)
`ifdef UART_RX_PARITY_EN
    ,
    .o_parity_error(pe)
`endif
  );
`ifndef UART_RX_PARITY_EN
  assign pe = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sampled 1 time unit after the rising edge.
  always begin
    exp_t e;
    int   lat;
    @(posedge clk);
    #1;
    if (rst) begin
      checks++;
      if (dbyte !== 8'h00 || dv !== 1'b0 || fe !== 1'b0 || busy !== 1'b0 || pe !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: byte=%h dv=%b fe=%b busy=%b pe=%b required 00 0 0 0 0", dbyte, dv, fe, busy, pe);
      end
      last_good = 8'h00;
    end else begin
      if ((dv + fe + pe) > 1) begin
        errors++;
        $display("FAIL strobe_exclusive: dv=%b fe=%b pe=%b at cycle %0d", dv, fe, pe, cyc);
      end
      if (dv || fe || pe) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: dv=%b fe=%b pe=%b required none at cycle %0d", dv, fe, pe, cyc);
        end else begin
          e   = sb.pop_front();
          lat = cyc - e.start;
          if ((e.kind == K_VALID && !dv) || (e.kind == K_FRAME && !fe) || (e.kind == K_PAR && !pe)) begin
            errors++;
            $display("FAIL strobe_kind: dv=%b fe=%b pe=%b required kind %0d (data %h)", dv, fe, pe, e.kind, e.data);
          end
          if (lat < LAT - 1 || lat > LAT + 2) begin
            errors++;
            $display("FAIL latency: got %0d cycles required %0d (-1/+2)", lat, LAT);
          end
          if (e.kind == K_VALID) last_good = e.data;
        end
      end
      checks++;
      if (dbyte !== last_good) begin
        errors++;
        $display("FAIL byte_hold: o_byte=%h required %h at cycle %0d", dbyte, last_good, cyc);
      end
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; leaves the line at the stop-bit level so frames can abut.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_flip, input bit abort4);
    exp_t e;
    logic par;
    par     = (^d) ^ PODD ^ par_flip;
    e.data  = d;
    e.start = cyc;
    e.kind  = !stop_ok ? K_FRAME : ((PAR_EN && par_flip) ? K_PAR : K_VALID);
    if (!abort4) sb.push_back(e);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == 4) begin
        repeat (CPB / 2) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_in_frame: o_busy=%b required 1", busy);
        end
        if (abort4) begin
          rst = 1'b1;
          rx  = 1'b1;
          repeat (2) @(negedge clk);
          rst = 1'b0;
          return;
        end
        repeat (CPB - CPB / 2) @(negedge clk);
      end else begin
        repeat (CPB) @(negedge clk);
      end
    end
    if (PAR_EN) begin
      rx = par;
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: o_busy=%b required 0", name, busy);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected strobes never seen", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    logic [7:0] d;
    bit         ok;
    int         gap;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(10);
    check_idle("idle_after_reset");

    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    idle(20);
    drain("frame_a5");

    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    idle(20);
    drain("back_to_back");

    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(30);
    check_idle("glitch_rejected");

    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_high_busy: o_busy=%b required 1", busy);
    end
    idle(40);
    check_idle("break_released");
    drain("framing_error");

    send_frame(8'h81, 1'b1, 1'b0, 1'b1);
    idle(40);
    check_idle("abort_by_reset");
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
    idle(20);
    drain("after_reset_7e");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b0, 1'b0);
    idle(10);
    send_frame(8'h03, 1'b1, 1'b1, 1'b0);
    idle(20);
    drain("parity");
`endif

    ok = 1'b1;
    for (int n = 0; n < 12; n++) begin
      d = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      send_frame(d, ok, PAR_EN ? ($urandom_range(0, 3) == 0) : 1'b0, 1'b0);
      gap = ok ? $urandom_range(0, 12) : $urandom_range(4, 12);
      if (gap > 0) idle(gap);
    end
    idle(20);
    drain("random_frames");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
